// File: rtl/message_process_ctrl.sv
// message_process_ctrl: round-robin two-requester scheduler and frame sequencer for the message datapath.
// Define MSGCTRL_GAP_EN to insert GAP_CYCLES idle cycles after each frame.
module message_process_ctrl #(
  parameter int MSG_WIDTH  = 5,
  parameter int GAP_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req0,
  input  logic [MSG_WIDTH-1:0] msg0,
  input  logic                 req1,
  input  logic [MSG_WIDTH-1:0] msg1,
  input  logic                 co,
  output logic                 ack0,
  output logic                 ack1,
  output logic [MSG_WIDTH-1:0] Msg,
  output logic                 ld_shiftreg,
  output logic                 init_cnt_4bit,
  output logic                 init_cnt_10bit,
  output logic                 busy,
  output logic                 done,
  output logic                 owner
);
`ifdef MSGCTRL_GAP_EN
  typedef enum logic [2:0] {IDLE, LOAD, SEND, DONE, GAP} state_t;
  logic [3:0] gap_q, gap_d;
`else
  typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_t;
`endif
  state_t state_q, state_d;
  logic [MSG_WIDTH-1:0] msg_q, msg_d;
  logic owner_q, owner_d, busy_q, busy_d, last_q, last_d;
  logic g0, g1;
  // On a tie the requester that did not win last time is granted
  assign g0 = req0 & (~req1 | last_q);
  assign g1 = req1 & (~req0 | ~last_q);
  assign ack0 = (state_q == IDLE) & g0 & ~reset;
  assign ack1 = (state_q == IDLE) & g1 & ~reset;
  assign ld_shiftreg = state_q == LOAD;
  assign init_cnt_4bit = state_q == LOAD;
  assign init_cnt_10bit = state_q == LOAD;
  assign done = state_q == DONE;
  assign Msg = msg_q;
  assign owner = owner_q;
  assign busy = busy_q;
  always_comb begin
    state_d = state_q;
    msg_d = msg_q;
    owner_d = owner_q;
    last_d = last_q;
`ifdef MSGCTRL_GAP_EN
    gap_d = gap_q;
`endif
    case (state_q)
      IDLE: if (g0 | g1) begin
        state_d = LOAD;
        msg_d = g1 ? msg1 : msg0;
        owner_d = g1;
        last_d = g1;
      end
      LOAD: state_d = SEND;
      SEND: state_d = co ? DONE : SEND;
`ifdef MSGCTRL_GAP_EN
      DONE: begin
        state_d = GAP;
        gap_d = 4'(GAP_CYCLES);
      end
      GAP: begin
        state_d = (gap_q == 4'd1) ? IDLE : GAP;
        gap_d = gap_q - 4'd1;
      end
`else
      DONE: state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
    owner_d = (state_d == IDLE) ? 1'b0 : owner_d;
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      msg_q <= '0;
      owner_q <= 1'b0;
      busy_q <= 1'b0;
      last_q <= 1'b1;
`ifdef MSGCTRL_GAP_EN
      gap_q <= 4'd0;
`endif
    end else begin
      state_q <= state_d;
      msg_q <= msg_d;
      owner_q <= owner_d;
      busy_q <= busy_d;
      last_q <= last_d;
`ifdef MSGCTRL_GAP_EN
      gap_q <= gap_d;
`endif
    end
  end
endmodule

// File: doc/message_process_ctrl.md
# message_process_ctrl

Two-requester scheduler and sequencer for the message-processing datapath, which serialises the 9-bit frame {4'b0101, Msg} and raises `co` when a frame is complete. The block arbitrates round-robin between two message sources and latches the winning 5-bit message. It drives the datapath's load and counter-init strobes, waits for frame completion on `co`, then reports `done`. It sits directly above the datapath; its `Msg`, `ld_shiftreg`, `init_cnt_4bit` and `init_cnt_10bit` outputs connect one-to-one to the datapath inputs.

## Interface
- MSG_WIDTH, 5, message width; must match the datapath `Msg` width.
- GAP_CYCLES, 4, idle cycles inserted after each frame; used only when `MSGCTRL_GAP_EN` is defined; legal range 1..15.

- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high.
- req0  in  1  requester 0 has a message pending; held until `ack0`.
- msg0  in  MSG_WIDTH  requester 0 message; stable while `req0` is high.
- req1  in  1  requester 1 has a message pending; held until `ack1`.
- msg1  in  MSG_WIDTH  requester 1 message.
- co  in  1  frame-complete flag from the datapath.
- ack0  out  1  one-cycle pulse: `msg0` accepted.
- ack1  out  1  one-cycle pulse: `msg1` accepted.
- Msg  out  MSG_WIDTH  latched message to the datapath.
- ld_shiftreg  out  1  load strobe to the datapath shift register.
- init_cnt_4bit  out  1  clear for the frame (bit) counter.
- init_cnt_10bit  out  1  clear for the bit-period counter.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at frame completion.
- owner  out  1  requester index of the frame in flight; 0 when idle.

## Operation
- States: IDLE, LOAD, SEND, DONE, plus GAP when `MSGCTRL_GAP_EN` is defined. Encoding is free.
- **IDLE**
  - If no request is present, stay in IDLE.
  - If exactly one `reqN` is high, grant it.
  - If both are high, grant the requester not equal to `last_grant`.
  - On a grant, in the same cycle: pulse `ackN`, latch `msgN` into `Msg`, set `owner=N`, set `last_grant=N`, then go to LOAD.
- **LOAD**
  - `ld_shiftreg=1`, `init_cnt_4bit=1`, `init_cnt_10bit=1` for exactly this one cycle.
  - Next state is SEND.
- **SEND**
  - All strobes are 0.
  - `Msg` is held stable.
  - If `co=1`, go to DONE; otherwise stay in SEND.
- **DONE**
  - `done=1` for this one cycle.
  - Next state is GAP if the macro is defined, otherwise IDLE.
- **GAP** (macro only)
  - Down-counter loads GAP_CYCLES on entry and decrements each cycle.
  - Go to IDLE when the counter reaches 1.
  - Requests are not sampled during GAP.
- `co` is ignored in IDLE, LOAD, DONE and GAP.
- `reqN` is sampled only in IDLE.
- A request arriving during SEND waits. It is granted on the first IDLE cycle after the frame.
- `last_grant` resets to 1, so requester 0 wins the first tie.
- `busy` and `owner` are registered outputs decoded from the state.
- `ackN`, the load/init strobes and `done` are Moore outputs of the current state.
  - Exception: `ackN` is a Mealy output combinational from `reqN` in IDLE.

## Timing
- **Reset values:**
  - `ack0`, `ack1`, `ld_shiftreg`, `init_cnt_4bit`, `init_cnt_10bit`, `busy`, `done` = 0.
  - `Msg` = 0, `owner` = 0.
  - State = IDLE, `last_grant` = 1, gap counter = 0.
- **Reset mid-frame** (any state): on the next edge, all outputs take their reset values and the FSM returns to IDLE.
  - No `done` is issued for the aborted frame.
  - The aborted requester's `ack` was already given, so the message is lost.
- **Grant latency:** `reqN` high in IDLE at cycle t gives `ackN` high at t. `ld_shiftreg` is high at t+1 and SEND starts at t+2.
- **Completion:** `co` high in SEND at cycle c gives `done` at c+1 and IDLE at c+2 without the macro.
- **Back-to-back:** with a continuous request and no macro, the next `ack` occurs at c+2. Minimum frame overhead is 3 cycles beyond the SEND duration.
- `co` already high on the first SEND cycle is honoured: DONE follows on the next cycle.

## Configuration
- `MSGCTRL_GAP_EN` defined:
  - GAP state and 4-bit gap counter are present.
  - GAP_CYCLES idle cycles are inserted after DONE; `busy` stays 1 through GAP.
  - Back-to-back `ack` spacing after `co` becomes GAP_CYCLES+2 cycles.
- `MSGCTRL_GAP_EN` undefined:
  - No GAP state; DONE goes directly to IDLE.
  - GAP_CYCLES is unused.

## Test plan
- **Single request:** reset, then `req0=1` with `msg0=5'h13` → `ack0` 1 cycle and `Msg=5'h13`. Next cycle all three strobes are 1 for 1 cycle. `busy=1`, `owner=0`. Force `co` 20 cycles later → `done` 1 cycle later, then IDLE with `busy=0`.
- **Tie and alternation:** `req0=req1=1` held continuously, `msg0=5'h01`, `msg1=5'h1E` → grants alternate 0,1,0,1 across four frames. `Msg` matches the owner each time.
- **Late request:** assert `req1` during SEND of requester 0's frame → no `ack1` until the first IDLE cycle after `done`. Then `ack1` fires, with spacing of 2 cycles after `co` (no macro).
- **Reset mid-frame:** assert `reset` 5 cycles into SEND → all outputs 0 and state IDLE next edge. No `done` pulse. Next tie is won by requester 0.
- **Spurious `co`:** `co=1` while IDLE and during LOAD → no state change, no `done`. `co` on the first SEND cycle → `done` on the following cycle.
- **Gap (macro defined, GAP_CYCLES=4):** continuous `req0` → `busy` stays high through 4 GAP cycles. Next `ack0` occurs 6 cycles after `co`.
